// File: rtl/ctrl_mac_tile.sv
// ctrl_mac_tile: groups ctrl_bus beats into dot products of runtime length acc_len and
// drives accumulator enables aligned to the multiplier pipeline. Protocol checker: CTRL_MAC_ERRCHK_EN.
module ctrl_mac_tile #(
    parameter int MAC_LAT = 2,
    parameter int LWIDTH  = 16
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic [2:0]        in_ctrl,
    input  logic [LWIDTH-1:0] acc_len,
    output logic [2:0]        out_ctrl,
    output logic              accum_rst,
    output logic              accum_we,
    output logic              mac_oe,
    output logic              busy,
    output logic              err
);
    // ctrl_bus bit layout: {start, valid, stop}
    localparam int WE_D    = MAC_LAT;
    localparam int OE_D    = MAC_LAT + 1;
    localparam int DRAIN_W = $clog2(MAC_LAT + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LWIDTH-1:0]   cnt_q, cnt_d;
    logic [LWIDTH-1:0]   len_q, len_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                busy_q;

    logic                start_i, valid_i, stop_i;
    logic                start_acc, beat, wrap;
    logic                rst_in, oe_in, stp_in;

    logic [WE_D-1:0]     we_p, rst_p;
    logic [OE_D-1:0]     oe_p, stp_p, sta_p;

    assign start_i = in_ctrl[2];
    assign valid_i = in_ctrl[1];
    assign stop_i  = in_ctrl[0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        drain_d   = drain_q;
        start_acc = 1'b0;
        beat      = 1'b0;
        wrap      = 1'b0;
        rst_in    = 1'b0;
        oe_in     = 1'b0;
        stp_in    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = RUN;
                    start_acc = 1'b1;
                    cnt_d     = '0;
                    len_d     = (acc_len == '0) ? LWIDTH'(1) : acc_len;
                end
            end
            RUN: begin
                if (valid_i) begin
                    beat   = 1'b1;
                    wrap   = (cnt_q == len_q - 1'b1);
                    rst_in = (cnt_q == '0);
                    oe_in  = wrap | stop_i;
                    stp_in = stop_i;
                    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
                    if (stop_i) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                // hold until the stop beat's enables have left the delay lines
                if (drain_q == DRAIN_W'(MAC_LAT)) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            drain_q <= drain_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // beat-aligned enables travel through shift registers matching the multiplier depth
    always_ff @(posedge clk) begin
        if (!xrst) begin
            we_p  <= '0;
            rst_p <= '0;
            oe_p  <= '0;
            stp_p <= '0;
            sta_p <= '0;
        end else begin
            we_p  <= WE_D'({we_p, beat});
            rst_p <= WE_D'({rst_p, rst_in});
            oe_p  <= OE_D'({oe_p, oe_in});
            stp_p <= OE_D'({stp_p, stp_in});
            sta_p <= OE_D'({sta_p, start_acc});
        end
    end

    assign accum_we  = we_p[WE_D-1];
    assign accum_rst = rst_p[WE_D-1];
    assign mac_oe    = oe_p[OE_D-1];
    assign out_ctrl  = {sta_p[OE_D-1], oe_p[OE_D-1], stp_p[OE_D-1]};
    assign busy      = busy_q;

`ifdef CTRL_MAC_ERRCHK_EN
    logic viol, err_q;

    always_comb begin
        viol = 1'b0;
        if (start_i && (state_q != IDLE)) viol = 1'b1;
        if ((valid_i || stop_i) && (state_q != RUN)) viol = 1'b1;
        if (stop_i && !valid_i) viol = 1'b1;
        if (start_i && (state_q == IDLE) && (acc_len == '0)) viol = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            err_q <= 1'b0;
        end else if (viol) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
